// File: rtl/datapath_arbiter_if.sv
// Bundle between requester front-ends, the datapath controls and the arbiter.
// The arbiter takes the master modport; the surrounding environment takes the slave modport.
interface datapath_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8,
  parameter int IDW   = $clog2(NREQ)
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic                  ready;
  logic                  error;
  logic                  ov_flag;
  logic [NREQ-1:0]       grant;
  logic                  load;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [1:0]            status;

  modport master (
    input  req, req_len, ready, error, ov_flag,
    output grant, load, flush, busy, done, done_id, status
  );

  modport slave (
    output req, req_len, ready, error, ov_flag,
    input  grant, load, flush, busy, done, done_id, status
  );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin owner of the shared load/calc datapath: grants one requester, paces
// load beats on ready, aborts with a one-cycle flush and reports every transfer on done.
module datapath_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8
) (
  input logic                clk,
  input logic                rst,
  datapath_arbiter_if.master bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [IDW-1:0]   ID_ONE    = IDW'(1'b1);
  localparam logic [IDW-1:0]   ID_ZERO   = IDW'(1'b0);
  localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0] CNT_ZERO  = LEN_W'(1'b0);
  localparam logic [NREQ-1:0]  GRANT_ONE = NREQ'(1'b1);
  localparam logic [1:0]       ST_OK     = 2'b00;
  localparam logic [1:0]       ST_ERR    = 2'b01;
  localparam logic [1:0]       ST_OVF    = 2'b10;
  localparam logic [1:0]       ST_ZERO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_FLUSH = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_q, status_d;

  logic [IDW-1:0]   cand_s [NREQ];
  logic             found_s;
  logic [IDW-1:0]   sel_s;
  logic [LEN_W-1:0] sel_len_s;

  // Rotating priority: candidate i is ptr+i, wrapping naturally at IDW bits.
  always_comb begin
    found_s   = 1'b0;
    sel_s     = ptr_q;
    sel_len_s = CNT_ZERO;
    for (int i = 0; i < NREQ; i++) begin
      cand_s[i] = ptr_q + IDW'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      sel_s   = (!found_s && bus.req[cand_s[i]]) ? cand_s[i] : sel_s;
      found_s = found_s | bus.req[cand_s[i]];
    end
    for (int j = 0; j < NREQ; j++) begin
      sel_len_s = (sel_s == IDW'(j)) ? bus.req_len[j*LEN_W +: LEN_W] : sel_len_s;
    end
  end

  // Next-state logic; aborts outrank the final beat, error outranks overflow.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          id_d  = sel_s;
          cnt_d = sel_len_s;
          if (sel_len_s == CNT_ZERO) begin
            status_d = ST_ZERO;
            state_d  = S_DONE;
          end else begin
            status_d = ST_OK;
            state_d  = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.error) begin
          status_d = ST_ERR;
          state_d  = S_FLUSH;
        end else if (bus.ov_flag) begin
          status_d = ST_OVF;
          state_d  = S_FLUSH;
        end else if (bus.ready) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            status_d = ST_OK;
            state_d  = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = id_q + ID_ONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= ID_ZERO;
      id_q     <= ID_ZERO;
      cnt_q    <= CNT_ZERO;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  // Everything but load decodes from registered state; load follows ready combinationally.
  assign bus.load    = (state_q == S_LOAD) & bus.ready & ~bus.error & ~bus.ov_flag;
  assign bus.grant   = ((state_q == S_LOAD) || (state_q == S_FLUSH)) ? (GRANT_ONE << id_q)
                                                                     : {NREQ{1'b0}};
  assign bus.flush   = (state_q == S_FLUSH);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.done_id = (state_q == S_DONE) ? id_q : ID_ZERO;
  assign bus.status  = (state_q == S_DONE) ? status_q : ST_OK;
endmodule

// File: tb/tb_datapath_arbiter.sv
// Scoreboard bench for datapath_arbiter: a transaction-level model predicts each
// transfer's outcome; an independent monitor compares every done pulse.
module tb_datapath_arbiter;
  localparam int NREQ  = 4;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();
  datapath_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int id;
    int status;
    int loads;
    int grants;
    int flushes;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   m_ptr    = 0;
  bit   mon_en   = 1'b0;
  int   acc_loads, acc_grants, acc_flushes;
  logic [NREQ-1:0] acc_mask;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.ready   = 1'b0;
    bus.error   = 1'b0;
    bus.ov_flag = 1'b0;
  endtask

  // Random ready/error/ov_flag for cycles in which the arbiter must ignore them.
  task automatic junk_inputs();
    bus.ready   = 1'($urandom_range(0, 1));
    bus.error   = 1'($urandom_range(0, 1));
    bus.ov_flag = 1'($urandom_range(0, 1));
  endtask

  // Monitor: accumulate activity per transfer, compare against the scoreboard on done.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc_loads = 0; acc_grants = 0; acc_flushes = 0; acc_mask = '0;
      end else begin
        if (bus.load) acc_loads++;
        if (bus.flush) acc_flushes++;
        if (bus.grant != '0) begin
          acc_grants++;
          acc_mask |= bus.grant;
          chk("busy_while_granted", int'(bus.busy), 1);
        end
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("done_id", int'(bus.done_id), mon_e.id);
            chk("status", int'(bus.status), mon_e.status);
            chk("load_count", acc_loads, mon_e.loads);
            chk("grant_cycles", acc_grants, mon_e.grants);
            chk("flush_cycles", acc_flushes, mon_e.flushes);
            chk("grant_mask", int'(acc_mask), (mon_e.grants != 0) ? (1 << mon_e.id) : 0);
            chk("done_busy", int'(bus.busy), 1);
            chk("done_grant", int'(bus.grant), 0);
          end
          acc_loads = 0; acc_grants = 0; acc_flushes = 0; acc_mask = '0;
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    mon_en  = 1'b0;
    rst     = 1'b1;
    bus.req = '0;
    quiet_inputs();
    repeat (cycles) step();
    rst = 1'b0;
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_load", int'(bus.load), 0);
    chk("rst_flush", int'(bus.flush), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_status", int'(bus.status), 0);
    m_ptr = 0;
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  // One transfer, started from an idle cycle. mode: 0 ready high, 1 toggling, 2 random.
  // abort_kind bit0 = error, bit1 = ov_flag, applied in LOAD cycle abort_at (0 = never).
  task automatic do_xfer(input logic [NREQ-1:0] mask, input logic [NREQ*LEN_W-1:0] lens,
                         input int mode, input int abort_at, input int abort_kind);
    int   id, len, loads, c;
    bit   fin;
    exp_t e;
    id = -1;
    for (int off = 0; off < NREQ; off++) begin
      if (id < 0 && mask[(m_ptr + off) % NREQ]) id = (m_ptr + off) % NREQ;
    end
    len = int'(lens[id*LEN_W +: LEN_W]);
    bus.req     = mask;
    bus.req_len = lens;
    quiet_inputs();
    step();
    bus.req   = '0;
    e.id      = id;
    e.loads   = 0;
    e.grants  = 0;
    e.flushes = 0;
    if (len == 0) begin
      e.status = 3;
      sb_q.push_back(e);
      junk_inputs();
      step();
    end else begin
      loads = 0;
      fin   = 1'b0;
      for (c = 1; c <= 2000 && !fin; c++) begin
        case (mode)
          0:       bus.ready = 1'b1;
          1:       bus.ready = ((c % 2) == 1);
          default: bus.ready = 1'($urandom_range(0, 1));
        endcase
        bus.error   = (c == abort_at) && ((abort_kind & 1) != 0);
        bus.ov_flag = (c == abort_at) && ((abort_kind & 2) != 0);
        e.grants = c;
        if (bus.error) begin
          e.status = 1; e.flushes = 1; e.grants = c + 1; fin = 1'b1;
        end else if (bus.ov_flag) begin
          e.status = 2; e.flushes = 1; e.grants = c + 1; fin = 1'b1;
        end else if (bus.ready) begin
          loads++;
          if (loads == len) begin
            e.status = 0; fin = 1'b1;
          end
        end
        if (fin) begin
          e.loads = loads;
          sb_q.push_back(e);
        end
        step();
      end
      if (!fin) chk("xfer_bound", 0, 1);
      if (e.flushes != 0) begin
        junk_inputs();
        step();
      end
      junk_inputs();
      step();
    end
    m_ptr = (id + 1) % NREQ;
    quiet_inputs();
  endtask

  initial begin
    logic [NREQ*LEN_W-1:0] lens_v;
    bus.req     = '0;
    bus.req_len = '0;
    quiet_inputs();
    rst = 1'b1;
    do_reset(2);

    // Reset in the middle of a transfer, after two beats.
    bus.req     = 4'b0001;
    bus.req_len = {8'd0, 8'd0, 8'd0, 8'd5};
    bus.ready   = 1'b1;
    step();
    bus.req = '0;
    step();
    step();
    do_reset(2);
    do_xfer(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 0, 0, 0);

    // Single transfer, steady then toggling ready.
    do_xfer(4'b0100, {8'd0, 8'd3, 8'd0, 8'd0}, 0, 0, 0);
    do_xfer(4'b0100, {8'd0, 8'd3, 8'd0, 8'd0}, 1, 0, 0);

    // Round robin from a fresh pointer, then 1001 after id 0.
    do_reset(1);
    repeat (5) do_xfer(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, 0);
    do_xfer(4'b1001, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, 0);

    // Aborts: error, overflow, both together.
    do_xfer(4'b0001, {8'd4, 8'd4, 8'd4, 8'd4}, 0, 2, 1);
    do_xfer(4'b0010, {8'd4, 8'd4, 8'd4, 8'd4}, 0, 2, 2);
    do_xfer(4'b0100, {8'd4, 8'd4, 8'd4, 8'd4}, 0, 2, 3);

    // Boundaries: zero length, maximum length, error on the final ready.
    do_xfer(4'b1000, {8'd0, 8'd7, 8'd7, 8'd7}, 0, 0, 0);
    do_xfer(4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, 0, 0, 0);
    do_xfer(4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}, 0, 2, 1);

    // Randomized traffic with idle gaps carrying junk control inputs.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        lens_v[i*LEN_W +: LEN_W] = ($urandom_range(0, 3) == 0) ? 8'd0
                                                              : 8'($urandom_range(1, 10));
      end
      do_xfer(4'($urandom_range(1, 15)), lens_v, int'($urandom_range(0, 2)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0,
              int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) begin
        junk_inputs();
        step();
      end
      quiet_inputs();
    end

    repeat (4) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
